// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM port arbiter.
//   state_e : arbiter FSM states
//   owner_t : id of the requester that owns the current transaction
package ram_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 4;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitq,
        StResp
    } state_e;

    typedef logic owner_t;

endpackage

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between two requesters.
// Ports:
//   CLOCK_50, Reset              : clock, asynchronous active-high reset
//   req/we/addr/wdata 0,1        : requester access (we=1 write, 0 read)
//   gnt0/1                       : one-cycle grant pulse (transaction accepted)
//   rvalid0/1, rdata             : one-cycle read-data strobe per requester, shared data
//   busy                         : FSM not idle
//   ram_addr/ram_wren/ram_wdata  : RAM drive
//   ram_q                        : RAM read data, valid one cycle after address is clocked
// Every output comes from a register or from state/owner registers only.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              CLOCK_50,
    input  logic              Reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_q
);

    state_e              state_q, state_d;
    logic                prio_q, prio_d;
    owner_t              owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    owner_t              winner;

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        winner  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    // Contention goes to prio; otherwise the lone requester wins.
                    winner  = (req0 && req1) ? prio_q : req1;
                    owner_d = winner;
                    we_d    = winner ? we1 : we0;
                    addr_d  = winner ? addr1 : addr0;
                    wdata_d = winner ? wdata1 : wdata0;
                    prio_d  = ~winner;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = we_q ? StIdle : StWaitq;
            end
            StWaitq: begin
                rdata_d = ram_q;
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign gnt0      = (state_q == StIssue) && !owner_q;
    assign gnt1      = (state_q == StIssue) && owner_q;
    assign rvalid0   = (state_q == StResp) && !owner_q;
    assign rvalid1   = (state_q == StResp) && owner_q;
    assign busy      = (state_q != StIdle);
    assign ram_wren  = (state_q == StIssue) && we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a behavioural 32x4 RAM.
module tb_ram_port_arbiter;

    logic       CLOCK_50 = 1'b0;
    logic       Reset    = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [4:0] addr0 = '0, addr1 = '0;
    logic [3:0] wdata0 = '0, wdata1 = '0;
    logic       gnt0, gnt1, rvalid0, rvalid1, busy, ram_wren;
    logic [3:0] rdata, ram_wdata;
    logic [4:0] ram_addr;
    logic [3:0] ram_q = '0;

    logic [3:0] ram_mem [32];
    logic [3:0] mem_m   [32];
    bit         prio_m;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         id;
        bit         we;
        logic [4:0] addr;
        logic [3:0] data;
        int         due;
    } exp_t;

    exp_t gq[$];
    exp_t rq[$];

    always #10 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    ram_port_arbiter dut (
        .CLOCK_50 (CLOCK_50),
        .Reset    (Reset),
        .req0     (req0),
        .req1     (req1),
        .we0      (we0),
        .we1      (we1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata    (rdata),
        .busy     (busy),
        .ram_addr (ram_addr),
        .ram_wren (ram_wren),
        .ram_wdata(ram_wdata),
        .ram_q    (ram_q)
    );

    // Single-port synchronous RAM, read-before-write.
    initial for (int i = 0; i < 32; i++) begin
        ram_mem[i] = '0;
        mem_m[i]   = '0;
    end
    always @(posedge CLOCK_50) begin
        if (ram_wren) ram_mem[ram_addr] <= ram_wdata;
        ram_q <= ram_mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a grant or read strobe.
    always @(negedge CLOCK_50) begin
        if (!Reset) begin
            exp_t e;
            if (gnt0 || gnt1) begin
                chk("gnt_onehot", {gnt0, gnt1}, {!gnt1, gnt1});
                if (gq.size() == 0) begin
                    chk("gnt_unexpected", {gnt0, gnt1}, 0);
                end else begin
                    e = gq.pop_front();
                    chk("gnt_id", gnt1, e.id);
                    chk("gnt_cycle", cyc, e.due);
                    chk("ram_wren", ram_wren, e.we);
                    chk("ram_addr", ram_addr, e.addr);
                    if (e.we) chk("ram_wdata", ram_wdata, e.data);
                end
            end else begin
                chk("wren_idle", ram_wren, 0);
            end
            if (rvalid0 || rvalid1) begin
                if (rq.size() == 0) begin
                    chk("rvalid_unexpected", {rvalid0, rvalid1}, 0);
                end else begin
                    e = rq.pop_front();
                    chk("rvalid_id", {rvalid0, rvalid1}, {!e.id, e.id});
                    chk("rvalid_cycle", cyc, e.due);
                    chk("rdata", rdata, e.data);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge CLOCK_50);
        while (busy && n < 50) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (busy) chk("idle_timeout", busy, 0);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge CLOCK_50);
    endtask

    // Push expectations for one access won at sample edge k.
    task automatic expect_acc(input bit id, input bit we, input logic [4:0] a,
                              input logic [3:0] d, input int k, input bit rv);
        exp_t e;
        e.id = id; e.we = we; e.addr = a; e.data = d; e.due = k;
        if (we) mem_m[a] = d;
        else e.data = mem_m[a];
        gq.push_back(e);
        if (!we && rv) begin
            e.due = k + 2;
            rq.push_back(e);
        end
        prio_m = ~id;
    endtask

    task automatic drive(input bit id, input bit we, input logic [4:0] a, input logic [3:0] d);
        if (id) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        else begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    endtask

    task automatic access(input bit id, input bit we, input logic [4:0] a,
                          input logic [3:0] d, input bit rv, output int k);
        wait_idle();
        drive(id, we, a, d);
        k = cyc + 1;
        expect_acc(id, we, a, d, k, rv);
        wait_cyc(k);
        if (id) req1 = 1'b0; else req0 = 1'b0;
    endtask

    initial begin
        int k;
        prio_m = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        chk("reset_outputs", {gnt0, gnt1, rvalid0, rvalid1, busy, ram_wren, rdata, ram_addr,
                              ram_wdata}, 0);
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK_50);
            chk("idle_outputs", {gnt0, gnt1, rvalid0, rvalid1, busy, ram_wren, rdata,
                                 ram_addr, ram_wdata}, 0);
        end

        // Single write then read-back.
        access(1'b0, 1'b1, 5'h03, 4'hA, 1'b1, k);
        access(1'b0, 1'b0, 5'h03, 4'h0, 1'b1, k);
        // Top address write from requester 1; leaves prio at 0.
        access(1'b1, 1'b1, 5'h1F, 4'h5, 1'b1, k);

        // Both reading continuously: strict alternation, grants 4 cycles apart.
        wait_idle();
        drive(1'b0, 1'b0, 5'h03, 4'h0);
        drive(1'b1, 1'b0, 5'h1F, 4'h0);
        k = cyc + 1;
        for (int i = 0; i < 4; i++) expect_acc(prio_m, 1'b0, prio_m ? 5'h1F : 5'h03, 4'h0,
                                                k + 4 * i, 1'b1);
        wait_cyc(k + 12);
        req0 = 1'b0;
        req1 = 1'b0;

        access(1'b0, 1'b0, 5'h1F, 4'h0, 1'b1, k);

        // Reset during WAITQ of a read: no rvalid, prio back to 0.
        access(1'b0, 1'b0, 5'h03, 4'h0, 1'b0, k);
        wait_cyc(k + 1);
        chk("waitq_busy", busy, 1);
        Reset = 1'b1;
        @(negedge CLOCK_50);
        chk("midreset_outputs", {gnt0, gnt1, rvalid0, rvalid1, busy, ram_wren, rdata}, 0);
        Reset = 1'b0;
        prio_m = 1'b0;
        repeat (3) begin
            @(negedge CLOCK_50);
            chk("no_rvalid_after_reset", {rvalid0, rvalid1, busy}, 0);
        end

        // Contended writes after reset: requester 0 first.
        drive(1'b0, 1'b1, 5'h0A, 4'h1);
        drive(1'b1, 1'b1, 5'h0B, 4'h2);
        k = cyc + 1;
        expect_acc(1'b0, 1'b1, 5'h0A, 4'h1, k, 1'b1);
        expect_acc(1'b1, 1'b1, 5'h0B, 4'h2, k + 2, 1'b1);
        wait_cyc(k);
        req0 = 1'b0;
        wait_cyc(k + 2);
        req1 = 1'b0;
        access(1'b1, 1'b0, 5'h0A, 4'h0, 1'b1, k);
        access(1'b0, 1'b0, 5'h0B, 4'h0, 1'b1, k);

        // Address 0 write/read-back; rdata must then hold.
        access(1'b0, 1'b1, 5'h00, 4'hF, 1'b1, k);
        access(1'b0, 1'b0, 5'h00, 4'h0, 1'b1, k);
        wait_idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge CLOCK_50);
            chk("rdata_hold", {rdata, ram_wren, busy}, {4'hF, 1'b0, 1'b0});
        end

        chk("gnt_queue_empty", gq.size(), 0);
        chk("rvalid_queue_empty", rq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
